// File: rtl/buffer_ring_pkg.sv
// rtl/buffer_ring_pkg.sv - shared types and sizing helpers for the buffer ring
package buffer_ring_pkg;

  typedef enum logic {
    MODE_PASS = 1'b0,
    MODE_RING = 1'b1
  } mode_e;

  function automatic int occ_width(input int depth);
    return $clog2(depth + 1);
  endfunction

endpackage

// File: rtl/buffer_stage.sv
// rtl/buffer_stage.sv - one valid/data register of the ring
// Flush clears only the valid bit; the payload keeps its stale value.
module buffer_stage #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush_i,
  input  logic             load_i,
  input  logic             valid_i,
  input  logic [WIDTH-1:0] data_i,
  output logic             valid_o,
  output logic [WIDTH-1:0] data_o
);

  logic             valid_q, valid_d;
  logic [WIDTH-1:0] data_q, data_d;

  always_comb begin
    valid_d = valid_q;
    data_d  = data_q;
    if (flush_i) begin
      valid_d = 1'b0;
    end else if (load_i) begin
      valid_d = valid_i;
      data_d  = data_i;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= 1'b0;
      data_q  <= '0;
    end else begin
      valid_q <= valid_d;
      data_q  <= data_d;
    end
  end

  assign valid_o = valid_q;
  assign data_o  = data_q;

endmodule

// File: rtl/buffer_ring.sv
// rtl/buffer_ring.sv - elastic valid/ready stage chain that can also recirculate
// PASS streams in_ -> out_; RING rotates all stages every cycle and counts laps.
module buffer_ring
  import buffer_ring_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4,
  parameter int LAPW  = 8
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          mode_i,
  input  logic                          flush_i,
  input  logic                          in_valid,
  output logic                          in_ready,
  input  logic [WIDTH-1:0]              in_data,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic [WIDTH-1:0]              out_data,
  output logic [occ_width(DEPTH)-1:0]   occ_o,
  output logic [LAPW-1:0]               lap_cnt_o
);

  localparam int OW = occ_width(DEPTH);
  localparam int PW = $clog2(DEPTH);

  mode_e            mode;
  logic             ring;
  logic [DEPTH-1:0] stage_valid;
  logic [DEPTH-1:0] stage_rdy;
  logic [DEPTH-1:0] valid_next;
  logic [WIDTH-1:0] stage_data [DEPTH];

  logic [PW-1:0]    phase_q, phase_d;
  logic [LAPW-1:0]  lap_q, lap_d;
  logic [OW-1:0]    occ_q, occ_d;

  assign mode = mode_e'(mode_i);
  assign ring = (mode == MODE_RING);

  // Ready ripples from out_ready towards stage 0: a stage can take data if it is
  // empty or anything downstream of it can move.
  always_comb begin : ready_chain
    logic acc;
    acc       = out_ready;
    stage_rdy = '0;
    for (int k = DEPTH - 1; k >= 0; k--) begin
      acc          = !stage_valid[k] | acc;
      stage_rdy[k] = acc;
    end
  end

  for (genvar k = 0; k < DEPTH; k++) begin : g_stage
    localparam int PREV = (k == 0) ? DEPTH - 1 : k - 1;
    logic             load;
    logic             v_in;
    logic [WIDTH-1:0] d_in;

    assign load = ring | stage_rdy[k];

    if (k == 0) begin : g_head
      assign v_in = ring ? stage_valid[PREV] : in_valid;
      assign d_in = ring ? stage_data[PREV]  : in_data;
    end else begin : g_body
      assign v_in = stage_valid[PREV];
      assign d_in = stage_data[PREV];
    end

    buffer_stage #(.WIDTH(WIDTH)) u_stage (
      .clk     (clk),
      .rst_n   (rst_n),
      .flush_i (flush_i),
      .load_i  (load),
      .valid_i (v_in),
      .data_i  (d_in),
      .valid_o (stage_valid[k]),
      .data_o  (stage_data[k])
    );

    assign valid_next[k] = flush_i ? 1'b0 : (load ? v_in : stage_valid[k]);
  end

  always_comb begin
    occ_d = '0;
    for (int k = 0; k < DEPTH; k++) begin
      occ_d = occ_d + OW'(valid_next[k]);
    end
  end

  // The phase only runs while rotating; leaving RING or flushing restarts it.
  always_comb begin
    phase_d = '0;
    lap_d   = lap_q;
    if (!flush_i && ring) begin
      if (phase_q == PW'(DEPTH - 1)) begin
        lap_d = lap_q + 1'b1;
      end else begin
        phase_d = phase_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      phase_q <= '0;
      lap_q   <= '0;
      occ_q   <= '0;
    end else begin
      phase_q <= phase_d;
      lap_q   <= lap_d;
      occ_q   <= occ_d;
    end
  end

  assign in_ready  = rst_n & ~flush_i & ~ring & stage_rdy[0];
  assign out_valid = ~ring & ~flush_i & stage_valid[DEPTH-1];
  assign out_data  = stage_data[DEPTH-1];
  assign occ_o     = occ_q;
  assign lap_cnt_o = lap_q;

endmodule

// File: tb/tb_buffer_ring.sv
// tb/tb_buffer_ring.sv - self-checking bench for buffer_ring
module tb_buffer_ring;

  localparam int WIDTH = 8;
  localparam int DEPTH = 4;
  localparam int LAPW  = 8;
  localparam int OW    = $clog2(DEPTH + 1);

  logic             clk = 1'b0;
  logic             rst_n;
  logic             mode_i;
  logic             flush_i;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_data;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_data;
  logic [OW-1:0]    occ_o;
  logic [LAPW-1:0]  lap_cnt_o;

  int errors = 0;
  int checks = 0;
  int exp_lap = 0;
  int ring_phase = 0;

  always #5 clk = ~clk;

  buffer_ring #(.WIDTH(WIDTH), .DEPTH(DEPTH), .LAPW(LAPW)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .mode_i    (mode_i),
    .flush_i   (flush_i),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .occ_o     (occ_o),
    .lap_cnt_o (lap_cnt_o)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    mode_i    = 1'b0;
    flush_i   = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    in_data   = '0;
  endtask

  task automatic ring_step();
    ring_phase++;
    if (ring_phase == DEPTH) begin
      ring_phase = 0;
      exp_lap    = (exp_lap + 1) % (1 << LAPW);
    end
  endtask

  task automatic drain();
    idle();
    out_ready = 1'b1;
    for (int i = 0; i < DEPTH + 2; i++) tick();
    ring_phase = 0;
    idle();
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    idle();
    in_valid  = 1'b1;
    out_ready = 1'b1;
    @(negedge clk);
    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL reset_in_ready: got %0b expected 0", in_ready); end
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %0b expected 0", out_valid); end
    checks++; if (out_data !== 8'h00) begin errors++; $display("FAIL reset_out_data: got %0h expected 00", out_data); end
    checks++; if (int'(occ_o) !== 0) begin errors++; $display("FAIL reset_occ: got %0d expected 0", occ_o); end
    checks++; if (int'(lap_cnt_o) !== 0) begin errors++; $display("FAIL reset_lap: got %0d expected 0", lap_cnt_o); end
    @(negedge clk);
    rst_n = 1'b1;
    idle();
    exp_lap = 0;
    ring_phase = 0;
    tick();
  endtask

  task automatic test_stream();
    int acc_cyc, first_cyc, n_out;
    acc_cyc = -1; first_cyc = -1; n_out = 0;
    idle();
    out_ready = 1'b1;
    for (int c = 0; c < 16; c++) begin
      in_valid = (c < 8);
      in_data  = WIDTH'(c + 1);
      @(negedge clk);
      if (in_valid && in_ready && acc_cyc < 0) acc_cyc = c;
      if (c >= 4 && c <= 11) begin
        checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL stream_b2b c=%0d: got out_valid %0b expected 1", c, out_valid); end
      end
      if (c >= 4 && c <= 8) begin
        checks++; if (int'(occ_o) !== 4) begin errors++; $display("FAIL stream_occ c=%0d: got %0d expected 4", c, occ_o); end
      end
      if (out_valid) begin
        if (first_cyc < 0) first_cyc = c;
        checks++; if (int'(out_data) !== n_out + 1) begin errors++; $display("FAIL stream_data: got %0h expected %0h", out_data, n_out + 1); end
        n_out++;
      end
      tick();
    end
    checks++; if (first_cyc - acc_cyc !== DEPTH) begin errors++; $display("FAIL stream_latency: got %0d expected %0d", first_cyc - acc_cyc, DEPTH); end
    checks++; if (n_out !== 8) begin errors++; $display("FAIL stream_count: got %0d expected 8", n_out); end
    drain();
  endtask

  task automatic test_full_push_pop();
    int n;
    idle();
    for (int i = 0; i < 4; i++) begin
      in_valid = 1'b1;
      in_data  = WIDTH'(8'hA0 + i);
      @(negedge clk);
      checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL fill_in_ready i=%0d: got %0b expected 1", i, in_ready); end
      tick();
    end
    in_data = 8'hA4;
    @(negedge clk);
    checks++; if (int'(occ_o) !== 4) begin errors++; $display("FAIL full_occ: got %0d expected 4", occ_o); end
    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL full_in_ready: got %0b expected 0", in_ready); end
    checks++; if (out_data !== 8'hA0) begin errors++; $display("FAIL full_out_data: got %0h expected a0", out_data); end
    tick();
    out_ready = 1'b1;
    @(negedge clk);
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL pushpop_in_ready: got %0b expected 1", in_ready); end
    checks++; if (out_valid !== 1'b1 || out_data !== 8'hA0) begin errors++; $display("FAIL pushpop_out: got %0b/%0h expected 1/a0", out_valid, out_data); end
    tick();
    idle();
    @(negedge clk);
    checks++; if (int'(occ_o) !== 4) begin errors++; $display("FAIL pushpop_occ: got %0d expected 4", occ_o); end
    tick();
    out_ready = 1'b1;
    n = 0;
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      if (out_valid) begin
        checks++; if (int'(out_data) !== 8'hA1 + n) begin errors++; $display("FAIL pushpop_drain: got %0h expected %0h", out_data, 8'hA1 + n); end
        n++;
      end
      tick();
    end
    checks++; if (n !== 4) begin errors++; $display("FAIL pushpop_drain_count: got %0d expected 4", n); end
    drain();
  endtask

  task automatic test_ring();
    logic [WIDTH-1:0] seen [4];
    logic [WIDTH-1:0] exp_out [4];
    exp_out[0] = 8'h00; exp_out[1] = 8'h11; exp_out[2] = 8'h22; exp_out[3] = 8'h33;
    idle();
    for (int i = 0; i < 3; i++) begin
      in_valid = 1'b1;
      in_data  = WIDTH'(8'h11 * (i + 1));
      tick();
    end
    mode_i   = 1'b1;
    in_valid = 1'b1;
    in_data  = 8'h5A;
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      checks++; if (in_ready !== 1'b0 || out_valid !== 1'b0) begin errors++; $display("FAIL ring_handshake c=%0d: got %0b/%0b expected 0/0", c, in_ready, out_valid); end
      if (c % 4 != 0) begin
        checks++; if (out_data !== exp_out[c % 4]) begin errors++; $display("FAIL ring_out_data c=%0d: got %0h expected %0h", c, out_data, exp_out[c % 4]); end
      end
      tick();
      ring_step();
    end
    idle();
    @(negedge clk);
    checks++; if (int'(lap_cnt_o) !== exp_lap) begin errors++; $display("FAIL ring_lap: got %0d expected %0d", lap_cnt_o, exp_lap); end
    checks++; if (int'(occ_o) !== 3) begin errors++; $display("FAIL ring_occ: got %0d expected 3", occ_o); end
    ring_phase = 0;
    out_ready = 1'b1;
    for (int c = 0; c < 4; c++) begin
      seen[c] = out_valid ? out_data : 8'h00;
      checks++; if (out_valid !== (c != 0) || seen[c] !== exp_out[c]) begin errors++; $display("FAIL ring_drain c=%0d: got %0b/%0h expected %0b/%0h", c, out_valid, seen[c], c != 0, exp_out[c]); end
      tick();
      @(negedge clk);
    end
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL ring_drain_end: got %0b expected 0", out_valid); end
    checks++; if (int'(lap_cnt_o) !== exp_lap) begin errors++; $display("FAIL ring_lap_hold: got %0d expected %0d", lap_cnt_o, exp_lap); end
    tick();
    drain();
  endtask

  task automatic test_flush();
    idle();
    for (int i = 0; i < 4; i++) begin
      in_valid = 1'b1;
      in_data  = WIDTH'(8'hB0 + i);
      tick();
    end
    in_valid = 1'b0;
    mode_i   = 1'b1;
    for (int c = 0; c < 3; c++) begin
      tick();
      ring_step();
    end
    flush_i  = 1'b1;
    in_valid = 1'b1;
    @(negedge clk);
    checks++; if (in_ready !== 1'b0 || out_valid !== 1'b0) begin errors++; $display("FAIL flush_cycle: got %0b/%0b expected 0/0", in_ready, out_valid); end
    tick();
    ring_phase = 0;
    idle();
    out_ready = 1'b1;
    @(negedge clk);
    checks++; if (int'(occ_o) !== 0) begin errors++; $display("FAIL flush_occ: got %0d expected 0", occ_o); end
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL flush_out_valid: got %0b expected 0", out_valid); end
    checks++; if (int'(lap_cnt_o) !== exp_lap) begin errors++; $display("FAIL flush_lap: got %0d expected %0d", lap_cnt_o, exp_lap); end
    tick();
    idle();
    mode_i = 1'b1;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      checks++; if (int'(lap_cnt_o) !== exp_lap) begin errors++; $display("FAIL flush_phase_lap c=%0d: got %0d expected %0d", c, lap_cnt_o, exp_lap); end
      tick();
      ring_step();
    end
    drain();
  endtask

  task automatic test_async_reset();
    idle();
    for (int i = 0; i < 3; i++) begin
      in_valid = 1'b1;
      in_data  = WIDTH'(8'hC0 + i);
      tick();
    end
    idle();
    tick();
    @(negedge clk);
    checks++; if (int'(occ_o) !== 3 || out_valid !== 1'b1) begin errors++; $display("FAIL pre_reset: got occ %0d valid %0b expected 3/1", occ_o, out_valid); end
    checks++; if (int'(lap_cnt_o) !== exp_lap) begin errors++; $display("FAIL pre_reset_lap: got %0d expected %0d", lap_cnt_o, exp_lap); end
    #2;
    rst_n = 1'b0;
    #1;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL async_out_valid: got %0b expected 0", out_valid); end
    checks++; if (int'(occ_o) !== 0) begin errors++; $display("FAIL async_occ: got %0d expected 0", occ_o); end
    checks++; if (int'(lap_cnt_o) !== 0) begin errors++; $display("FAIL async_lap: got %0d expected 0", lap_cnt_o); end
    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL async_in_ready: got %0b expected 0", in_ready); end
    exp_lap = 0;
    ring_phase = 0;
    @(negedge clk);
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_lap_wrap();
    idle();
    mode_i = 1'b1;
    for (int c = 0; c < 4 * 256; c++) begin
      @(negedge clk);
      checks++; if (int'(lap_cnt_o) !== exp_lap) begin errors++; $display("FAIL lap_wrap c=%0d: got %0d expected %0d", c, lap_cnt_o, exp_lap); end
      tick();
      ring_step();
    end
    @(negedge clk);
    checks++; if (int'(lap_cnt_o) !== 0) begin errors++; $display("FAIL lap_wrap_end: got %0d expected 0", lap_cnt_o); end
    drain();
  endtask

  task automatic test_random();
    logic [WIDTH-1:0] q [$];
    logic exp_in_ready;
    drain();
    for (int c = 0; c < 400; c++) begin
      in_valid  = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 2) != 0);
      flush_i   = ($urandom_range(0, 31) == 0);
      in_data   = WIDTH'($urandom);
      @(negedge clk);
      exp_in_ready = !flush_i && (out_ready || q.size() < DEPTH);
      checks++; if (in_ready !== exp_in_ready) begin errors++; $display("FAIL rand_in_ready c=%0d: got %0b expected %0b", c, in_ready, exp_in_ready); end
      checks++; if (int'(occ_o) !== q.size()) begin errors++; $display("FAIL rand_occ c=%0d: got %0d expected %0d", c, occ_o, q.size()); end
      if (out_valid && (flush_i || q.size() == 0)) begin
        errors++; checks++;
        $display("FAIL rand_spurious_valid c=%0d: got 1 expected 0", c);
      end else if (out_valid && out_ready) begin
        checks++; if (out_data !== q[0]) begin errors++; $display("FAIL rand_data c=%0d: got %0h expected %0h", c, out_data, q[0]); end
        void'(q.pop_front());
      end
      if (in_valid && exp_in_ready) q.push_back(in_data);
      if (flush_i) q.delete();
      tick();
    end
    idle();
    out_ready = 1'b1;
    for (int c = 0; c < 2 * DEPTH + 2; c++) begin
      @(negedge clk);
      if (out_valid) begin
        if (q.size() == 0) begin
          errors++; checks++;
          $display("FAIL rand_drain_extra: got %0h expected none", out_data);
        end else begin
          checks++; if (out_data !== q[0]) begin errors++; $display("FAIL rand_drain: got %0h expected %0h", out_data, q[0]); end
          void'(q.pop_front());
        end
      end
      tick();
    end
    checks++; if (q.size() !== 0 || int'(occ_o) !== 0) begin errors++; $display("FAIL rand_final: got left %0d occ %0d expected 0/0", q.size(), occ_o); end
    idle();
  endtask

  initial begin
    test_reset();
    test_stream();
    test_full_push_pop();
    test_ring();
    test_flush();
    test_async_reset();
    test_lap_wrap();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

endmodule

// File: doc/buffer_ring.md
Name: buffer_ring

Overview:
- Parametrised, elastic successor to the fixed three-net buffer ring (a -> b -> c -> a).
- Chain of DEPTH valid/ready register stages, each WIDTH bits wide.
- Two operating modes:
  - PASS: the chain acts as a streaming pipeline from the in_ port to the out_ port.
  - RING: the last stage feeds stage 0 and contents recirculate.
- Sits between producer and consumer blocks as a retiming/buffering element, and doubles as a recirculating test ring.

Parameters:
- WIDTH, 8: data bits per stage.
- DEPTH, 4: number of register stages; legal range 2..64.
- LAPW, 8: width of the lap counter.

Ports:
- clk  in  1  single clock; all state updates on the rising edge.
- rst_n  in  1  reset, asynchronous assert, active-low.
- mode_i  in  1  0 = PASS, 1 = RING.
- flush_i  in  1  synchronous clear of all stage valid bits.
- in_valid  in  1  producer has data.
- in_ready  out  1  chain accepts in_data this cycle.
- in_data  in  WIDTH  input payload.
- out_valid  out  1  last stage holds data (PASS only).
- out_ready  in  1  consumer accepts out_data.
- out_data  out  WIDTH  last-stage payload.
- occ_o  out  $clog2(DEPTH+1)  number of valid stages.
- lap_cnt_o  out  LAPW  completed RING rotations, wrapping.

Behaviour:
- Reset (rst_n low, asynchronous):
  - all stage valid bits = 0 and all stage data = 0.
  - occ_o = 0, lap_cnt_o = 0, internal phase counter = 0.
  - in_ready = 0 while rst_n is low.
  - out_valid = 0 and out_data = 0.
  - A reset mid-operation discards all contents.
- Stage rule in PASS mode:
  - Stage k advances when its downstream ready is high. Downstream ready = out_ready for the last stage, otherwise stage k+1 ready.
  - Stage k ready = !v[k] | downstream ready, so the ready chain is combinational from out_ready to in_ready.
  - On advance, stage k loads stage k-1 (or in_data/in_valid for stage 0).
  - Full throughput: 1 beat/cycle.
  - Latency when unstalled: DEPTH cycles from the in_valid&in_ready edge to out_valid.
- PASS boundaries:
  - All stages valid and out_ready=0 -> in_ready=0 (full).
  - Full and out_ready=1 -> in_ready=1 in the same cycle, so simultaneous push and pop is allowed.
  - All stages empty -> out_valid=0.
  - out_data is held stable while out_valid=1 and out_ready=0.
- RING mode:
  - in_ready=0 and out_valid=0; out_data still shows last-stage data.
  - Every cycle all stages rotate unconditionally: stage 0 loads stage DEPTH-1, stage k loads stage k-1.
  - Valid bits rotate with the data, so bubbles are preserved.
  - There is no ready gating, and the combinational loop is broken.
  - A phase counter (0..DEPTH-1) increments each RING cycle.
  - When the phase counter wraps, lap_cnt_o increments, wrapping at 2^LAPW. The increment happens even if the ring is empty.
- Mode switching:
  - mode_i is sampled each cycle and takes effect on that edge.
  - RING -> PASS: contents stay in place, the phase counter clears to 0, and lap_cnt_o holds its value.
  - PASS -> RING: any in-flight beat not handshaken stays with the producer.
- flush_i:
  - Highest priority after reset.
  - All valid bits clear and the phase counter clears on the edge, in either mode.
  - in_ready=0 and out_valid=0 during the flush cycle; no handshake completes.
  - Data registers keep stale values.
  - lap_cnt_o is unaffected by flush.
- occ_o is a registered population count of the valid bits. It reflects the state after the last edge and never exceeds DEPTH.

Decomposition:
- Package buffer_ring_pkg:
  - mode enum MODE_PASS=0, MODE_RING=1.
  - occupancy width function (clog2 of DEPTH+1).
- Sub-module buffer_stage: one valid/data register carrying a load enable, a next-valid/next-data mux input and flush.
- Top level: generate-loop over buffer_stage plus the ready chain, mode mux, phase/lap counters and occupancy counter.

Test Plan (WIDTH=8, DEPTH=4):
- Stream 0x01..0x08 with out_ready=1 -> first out_valid 4 cycles after the first accept; outputs 0x01..0x08 in order back to back; occ_o steady at 4.
- Push 0xA0..0xA3 with out_ready=0 -> occ_o=4, in_ready=0. Then out_ready=1 with in_valid=1 (0xA4) -> pop 0xA0 and accept 0xA4 in the same cycle; occ_o stays 4.
- Load 0x11,0x22,0x33 (one bubble), set mode_i=1 for 8 cycles -> lap_cnt_o=2, in_ready=0, out_valid=0. Return to PASS -> drain yields 0x11,0x22,0x33 in the original order, with the bubble preserved.
- Full ring, assert flush_i for 1 cycle -> next cycle occ_o=0, out_valid=0; lap_cnt_o unchanged.
- Mid-stream (occ_o=3), pull rst_n low between edges -> out_valid, occ_o and lap_cnt_o drop to 0 immediately, without waiting for a clock.
- RING for 4*256 cycles with LAPW=8 -> lap_cnt_o wraps 255 -> 0.
